// File: rtl/difftest_sched_pkg.sv
// Shared encodings for the difftest step scheduler: controller states and halt causes.
package difftest_sched_pkg;

    typedef logic [2:0] sched_state_t;

    localparam sched_state_t ST_INIT = 3'd0;
    localparam sched_state_t ST_RUN  = 3'd1;
    localparam sched_state_t ST_REQ  = 3'd2;
    localparam sched_state_t ST_WAIT = 3'd3;
    localparam sched_state_t ST_HALT = 3'd4;

    typedef enum logic [1:0] {
        CAUSE_NONE     = 2'd0,
        CAUSE_FAIL     = 2'd1,
        CAUSE_OVERFLOW = 2'd2,
        CAUSE_MAXCYC   = 2'd3
    } halt_cause_t;

endpackage

// File: rtl/difftest_step_accum.sv
// Saturating step accumulator: adds the per-cycle commit count, subtracts an issued batch,
// and raises a sticky overflow flag whenever the result had to be clipped.
module difftest_step_accum #(
    parameter int STEP_WIDTH  = 8,
    parameter int BATCH_WIDTH = 16
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   enable,
    input  logic [STEP_WIDTH-1:0]  add,
    input  logic                   sub_en,
    input  logic [BATCH_WIDTH-1:0] sub,
    output logic [BATCH_WIDTH-1:0] value,
    output logic                   ovf
);

    localparam logic [BATCH_WIDTH:0] SAT = {1'b0, {BATCH_WIDTH{1'b1}}};

    logic [BATCH_WIDTH:0] add_ext;
    logic [BATCH_WIDTH:0] sub_ext;
    logic [BATCH_WIDTH:0] sum;

    // One extra bit of headroom; sub never exceeds value, so only the top end can clip.
    always_comb begin
        add_ext = {{(BATCH_WIDTH + 1 - STEP_WIDTH){1'b0}}, add};
        sub_ext = sub_en ? {1'b0, sub} : '0;
        sum     = {1'b0, value} + add_ext - sub_ext;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            value <= '0;
            ovf   <= 1'b0;
        end else if (enable) begin
            if (sum > SAT) begin
                value <= '1;
                ovf   <= 1'b1;
            end else begin
                value <= sum[BATCH_WIDTH-1:0];
            end
        end
    end

endmodule

// File: rtl/difftest_step_sched.sv
// Difftest step scheduler: gathers commit steps, runs the checker init handshake, and issues
// one batched step request at a time until the checker fails or a sticky limit trips.
//
//   state | meaning
//   INIT  | init_valid raised (after first cycle) until init_done
//   RUN   | accumulate; issue a batch or act on sticky ovf/maxcyc
//   REQ   | req_valid held with a stable req_step until req_ready
//   WAIT  | request accepted, waiting for rsp_valid
//   HALT  | terminal until reset; accumulator and cycle_count frozen
module difftest_step_sched
    import difftest_sched_pkg::*;
#(
    parameter int STEP_WIDTH    = 8,
    parameter int BATCH_WIDTH   = 16,
    parameter int MAX_BATCH     = 64,
    parameter int FLUSH_TIMEOUT = 32,
    parameter int CYCLE_WIDTH   = 64
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic [STEP_WIDTH-1:0]  in_step,
    input  logic                   flush,
    input  logic [CYCLE_WIDTH-1:0] max_cycles,
    output logic                   init_valid,
    input  logic                   init_done,
    output logic                   req_valid,
    input  logic                   req_ready,
    output logic [BATCH_WIDTH-1:0] req_step,
    input  logic                   rsp_valid,
    input  logic                   rsp_fail,
    output logic [CYCLE_WIDTH-1:0] cycle_count,
    output logic [BATCH_WIDTH-1:0] pending,
    output logic                   halt,
    output logic [1:0]             halt_cause
);

    localparam int                     IDLE_W    = $clog2(FLUSH_TIMEOUT + 1);
    localparam logic [IDLE_W-1:0]      IDLE_MAX  = IDLE_W'(FLUSH_TIMEOUT);
    localparam logic [BATCH_WIDTH-1:0] BATCH_MAX = BATCH_WIDTH'(MAX_BATCH);

    sched_state_t           state;
    sched_state_t           state_next;
    logic [1:0]             cause_next;
    logic                   armed;
    logic [IDLE_W-1:0]      idle_cnt;
    logic                   maxcyc;
    logic                   ovf;
    logic                   handshake;
    logic                   issue;
    logic [BATCH_WIDTH-1:0] acc;

    difftest_step_accum #(
        .STEP_WIDTH (STEP_WIDTH),
        .BATCH_WIDTH(BATCH_WIDTH)
    ) u_accum (
        .clock  (clock),
        .reset_n(reset_n),
        .enable (state != ST_HALT),
        .add    (in_step),
        .sub_en (handshake),
        .sub    (req_step),
        .value  (acc),
        .ovf    (ovf)
    );

    // armed keeps init_valid low while reset is held and for the release cycle itself
    assign init_valid = armed && (state == ST_INIT);
    assign req_valid  = (state == ST_REQ);
    assign halt       = (state == ST_HALT);
    assign handshake  = req_valid && req_ready;
    assign pending    = acc;
    assign issue      = (acc >= BATCH_MAX) ||
                        ((acc != '0) && ((idle_cnt >= IDLE_MAX) || flush));

    always_comb begin
        state_next = state;
        cause_next = halt_cause;
        case (state)
            ST_INIT: begin
                if (init_valid && init_done) state_next = ST_RUN;
            end
            ST_RUN: begin
                if (ovf) begin
                    state_next = ST_HALT;
                    cause_next = CAUSE_OVERFLOW;
                end else if (maxcyc) begin
                    state_next = ST_HALT;
                    cause_next = CAUSE_MAXCYC;
                end else if (issue) begin
                    state_next = ST_REQ;
                end
            end
            ST_REQ: begin
                if (req_ready) state_next = ST_WAIT;
            end
            ST_WAIT: begin
                if (rsp_valid) begin
                    if (rsp_fail) begin
                        state_next = ST_HALT;
                        cause_next = CAUSE_FAIL;
                    end else begin
                        state_next = ST_RUN;
                    end
                end
            end
            default: state_next = ST_HALT;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state       <= ST_INIT;
            halt_cause  <= CAUSE_NONE;
            armed       <= 1'b0;
            req_step    <= '0;
            idle_cnt    <= '0;
            cycle_count <= '0;
            maxcyc      <= 1'b0;
        end else begin
            state      <= state_next;
            halt_cause <= cause_next;
            armed      <= 1'b1;
            if ((state == ST_RUN) && (state_next == ST_REQ))
                req_step <= (acc >= BATCH_MAX) ? BATCH_MAX : acc;
            if (state != ST_HALT) begin
                cycle_count <= cycle_count + 1'b1;
                if ((max_cycles != '0) && (cycle_count >= max_cycles))
                    maxcyc <= 1'b1;
                if ((in_step != '0) || handshake)
                    idle_cnt <= '0;
                else if (idle_cnt < IDLE_MAX)
                    idle_cnt <= idle_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_difftest_step_sched.sv
// Randomised and directed bench for difftest_step_sched against a transaction-level reference.
module tb_difftest_step_sched;

    logic        clock = 1'b0;
    logic        reset_n = 1'b1;
    logic [7:0]  in_step = '0;
    logic        flush = 1'b0;
    logic [63:0] max_cycles = '0;
    logic        init_valid;
    logic        init_done = 1'b0;
    logic        req_valid;
    logic        req_ready = 1'b0;
    logic [15:0] req_step;
    logic        rsp_valid = 1'b0;
    logic        rsp_fail = 1'b0;
    logic [63:0] cycle_count;
    logic [15:0] pending;
    logic        halt;
    logic [1:0]  halt_cause;

    difftest_step_sched dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .in_step    (in_step),
        .flush      (flush),
        .max_cycles (max_cycles),
        .init_valid (init_valid),
        .init_done  (init_done),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_step   (req_step),
        .rsp_valid  (rsp_valid),
        .rsp_fail   (rsp_fail),
        .cycle_count(cycle_count),
        .pending    (pending),
        .halt       (halt),
        .halt_cause (halt_cause)
    );

    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_err = 0;

    // stimulus knobs
    int in_mode = 0, in_fix = 0, flush_pct = 0, ready_pct = 100;
    int rsp_lat_min = 0, rsp_lat_max = 0, init_wait = 3;
    bit flush_fix = 0, fail_knob = 0, noise = 0;

    // reference view of the scheduler
    int     m_acc, m_idle, m_reqstep, m_cause, rsp_cnt, init_cnt;
    longint m_cyc, last_rsp_cyc;
    bit     m_ovf, m_maxc, m_halted, m_initv, m_init_done, m_reqv, m_await;
    int     issued[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_acc = 0; m_idle = 0; m_reqstep = 0; m_cause = 0; rsp_cnt = 0; init_cnt = 0;
        m_cyc = 0; last_rsp_cyc = 0;
        m_ovf = 0; m_maxc = 0; m_halted = 0; m_initv = 0; m_init_done = 0;
        m_reqv = 0; m_await = 0;
    endtask

    task automatic do_reset(input logic [63:0] maxc);
        #3 reset_n = 1'b0;
        #1;
        check("rst_init_valid", init_valid, 0);
        check("rst_req_valid", req_valid, 0);
        check("rst_halt", halt, 0);
        check("rst_halt_cause", halt_cause, 0);
        check("rst_pending", pending, 0);
        check("rst_cycle_count", cycle_count, 0);
        in_step = '0; flush = 1'b0; init_done = 1'b0; req_ready = 1'b0;
        rsp_valid = 1'b0; rsp_fail = 1'b0;
        max_cycles = maxc;
        model_reset();
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset_n = 1'b1;
    endtask

    task automatic one_cycle();
        bit hs, run_b, issue_b, ovf_new, maxc_new;
        int sum;
        if (in_mode == 1)
            in_step = ($urandom_range(99) < 40) ? 8'($urandom_range(24)) : 8'd0;
        else
            in_step = 8'(in_fix);
        flush = flush_fix || ($urandom_range(99) < flush_pct);
        req_ready = ($urandom_range(99) < ready_pct);
        rsp_valid = 1'b0;
        rsp_fail  = 1'b0;
        if (m_await) begin
            if (rsp_cnt == 0) begin
                rsp_valid = 1'b1;
                rsp_fail  = fail_knob;
            end else begin
                rsp_cnt--;
            end
        end else if (noise && $urandom_range(9) == 0) begin
            // stray responses outside a pending request must be ignored
            rsp_valid = 1'b1;
            rsp_fail  = 1'($urandom_range(1));
        end
        init_done = 1'b0;
        if (m_initv) begin
            init_cnt++;
            init_done = (init_cnt >= init_wait);
        end

        hs      = m_reqv && req_ready;
        run_b   = m_init_done && !m_reqv && !m_await && !m_halted;
        issue_b = (m_acc >= 64) || (m_acc > 0 && (m_idle >= 32 || flush));

        @(posedge clock);
        #1;

        if (!m_halted) begin
            if (!m_init_done) begin
                if (m_initv && init_done) m_init_done = 1;
                m_initv = !m_init_done;
            end else if (run_b) begin
                if (m_ovf) begin
                    m_halted = 1; m_cause = 2;
                end else if (m_maxc) begin
                    m_halted = 1; m_cause = 3;
                end else if (issue_b) begin
                    m_reqv = 1;
                    m_reqstep = (m_acc < 64) ? m_acc : 64;
                    issued.push_back(m_reqstep);
                end
            end else if (m_reqv) begin
                if (hs) begin
                    m_reqv = 0;
                    m_await = 1;
                    rsp_cnt = $urandom_range(rsp_lat_max, rsp_lat_min);
                end
            end else if (m_await && rsp_valid) begin
                m_await = 0;
                last_rsp_cyc = m_cyc;
                if (rsp_fail) begin
                    m_halted = 1; m_cause = 1;
                end
            end
            sum = m_acc + int'(in_step) - (hs ? m_reqstep : 0);
            ovf_new = (sum > 65535);
            m_acc = ovf_new ? 65535 : sum;
            m_idle = (in_step != 0 || hs) ? 0 : ((m_idle < 32) ? m_idle + 1 : 32);
            maxc_new = (max_cycles != 0) && (m_cyc >= longint'(max_cycles));
            m_cyc++;
            m_ovf  = m_ovf | ovf_new;
            m_maxc = m_maxc | maxc_new;
        end

        check("pending", pending, m_acc);
        check("cycle_count", cycle_count, m_cyc);
        check("init_valid", init_valid, m_initv);
        check("req_valid", req_valid, m_reqv);
        if (m_reqv) check("req_step", req_step, m_reqstep);
        check("halt", halt, m_halted);
        check("halt_cause", halt_cause, m_cause);
    endtask

    task automatic wait_quiet(input int bound);
        int n = 0;
        while (!(m_init_done && !m_reqv && !m_await && !m_halted) && n < bound) begin
            one_cycle();
            n++;
        end
        check("quiet_reached", (m_init_done && !m_reqv && !m_await && !m_halted), 1);
    endtask

    task automatic run_until_halt(input int bound);
        int n = 0;
        while (!m_halted && n < bound) begin
            one_cycle();
            n++;
        end
        check("halt_reached", m_halted, 1);
    endtask

    initial begin
        int cnt, prior;
        longint cyc_at;

        // init handshake with steps arriving during INIT
        do_reset(64'd0);
        in_fix = 0; init_wait = 3;
        one_cycle();
        in_fix = 2;
        repeat (3) one_cycle();
        in_fix = 0;
        check("init_pulses", init_cnt, 3);
        check("init_pending", pending, 6);
        check("init_exit", init_valid, 0);

        // full batches with a short response latency
        issued.delete();
        in_fix = 8; ready_pct = 100; rsp_lat_min = 1; rsp_lat_max = 1;
        repeat (40) one_cycle();
        check("batch_count", issued.size() >= 3, 1);
        if (issued.size() > 0) check("batch_first_step", issued[0], 64);

        // idle timeout flush of a small residue
        in_fix = 0; rsp_lat_min = 0; rsp_lat_max = 0;
        repeat (150) one_cycle();
        wait_quiet(100);
        check("drained", pending, 0);
        in_fix = 5;
        one_cycle();
        in_fix = 0;
        cnt = 0;
        while (!req_valid && cnt < 100) begin
            one_cycle();
            cnt++;
        end
        check("timeout_delay", cnt, 33);
        check("timeout_step", req_step, 5);

        // forced flush issues on the very next RUN cycle
        wait_quiet(50);
        in_fix = 5;
        one_cycle();
        in_fix = 0; flush_fix = 1;
        one_cycle();
        flush_fix = 0;
        check("flush_issue", req_valid, 1);
        check("flush_step", req_step, 5);

        // backpressure: request held stable while steps keep arriving
        wait_quiet(50);
        ready_pct = 0; in_fix = 20;
        one_cycle();
        in_fix = 0; flush_fix = 1;
        one_cycle();
        flush_fix = 0;
        check("bp_issue", req_valid, 1);
        prior = m_acc;
        in_fix = 1;
        repeat (10) one_cycle();
        check("bp_hold_valid", req_valid, 1);
        check("bp_hold_step", req_step, 20);
        ready_pct = 100; in_fix = 0;
        one_cycle();
        check("bp_after_hs", pending, prior + 10 - 20);

        // randomised traffic with stray responses
        in_mode = 1; flush_pct = 5; ready_pct = 60; rsp_lat_min = 0; rsp_lat_max = 4; noise = 1;
        repeat (1500) one_cycle();

        // reset lands asynchronously, possibly mid-request; then a failing response
        do_reset(64'd0);
        in_mode = 0; flush_pct = 0; ready_pct = 100; rsp_lat_min = 2; rsp_lat_max = 2;
        init_wait = $urandom_range(4, 1);
        in_fix = 8; fail_knob = 1;
        run_until_halt(200);
        check("fail_halt", halt, 1);
        check("fail_cause", halt_cause, 1);
        cyc_at = m_cyc;
        in_fix = 20;
        repeat (10) one_cycle();
        check("fail_frozen_cycles", cycle_count, cyc_at);
        fail_knob = 0;

        // max-cycle limit reached while a response is outstanding
        do_reset(64'd100);
        noise = 0; init_wait = 1;
        in_fix = 8; ready_pct = 100; rsp_lat_min = 60; rsp_lat_max = 60;
        run_until_halt(400);
        check("maxcyc_cause", halt_cause, 3);
        check("maxcyc_rsp_late", last_rsp_cyc > 100, 1);

        // accumulator saturation under backpressure
        do_reset(64'd0);
        init_wait = 2; in_fix = 255; ready_pct = 0;
        repeat (300) one_cycle();
        check("ovf_saturated", pending, 65535);
        check("ovf_no_halt_yet", halt, 0);
        in_fix = 0; ready_pct = 100; rsp_lat_min = 1; rsp_lat_max = 1;
        run_until_halt(50);
        check("ovf_cause", halt_cause, 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog observed=running expected=finished");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/difftest_step_sched.md
Name: difftest_step_sched

Overview:
- Schedules difftest checking between the DUT commit stream and the reference checker (DPI nstep call or GFIFO transport).
- Accumulates per-cycle commit step counts and sequences the one-time checker init.
- Issues batched step requests, one outstanding at a time, over a valid/ready handshake.
- Halts on checker failure, accumulator overflow or max-cycle limit. Sits between SimTop's difftest_step output and the testbench checker interface.

Parameters:
STEP_WIDTH, 8, width of per-cycle commit step count
BATCH_WIDTH, 16, width of accumulator and request step field
MAX_BATCH, 64, request issued as soon as accumulator >= this; request size capped at this
FLUSH_TIMEOUT, 32, cycles without new steps before a non-empty accumulator is flushed
CYCLE_WIDTH, 64, width of cycle counter and max_cycles

Ports:
clock  in  1  sole clock
reset_n  in  1  asynchronous reset, active-low
in_step  in  STEP_WIDTH  steps committed this cycle (already delayed one cycle upstream)
flush  in  1  force issue of a non-empty accumulator at the next RUN cycle
max_cycles  in  CYCLE_WIDTH  cycle limit; 0 = unlimited; static after reset
init_valid  out  1  checker init request
init_done  in  1  checker init acknowledge
req_valid  out  1  step request valid
req_ready  in  1  checker accepts request
req_step  out  BATCH_WIDTH  steps in request, 1..MAX_BATCH
rsp_valid  in  1  checker result valid (single-cycle pulse)
rsp_fail  in  1  checker mismatch; qualified by rsp_valid
cycle_count  out  CYCLE_WIDTH  cycles since reset release; frozen in HALT
pending  out  BATCH_WIDTH  current accumulator value
halt  out  1  simulation must stop
halt_cause  out  2  0 none, 1 FAIL, 2 OVERFLOW, 3 MAXCYC

Behaviour:
Reset:
- Async assert forces state INIT.
- All outputs 0; accumulator, idle counter, cycle_count and sticky flags cleared.
- Reset mid-request abandons the request; the checker must also be reset.

States INIT, RUN, REQ, WAIT, HALT.
- INIT: init_valid=1 from the first cycle after reset release until the cycle init_done=1 (inclusive). Next state is RUN.
- RUN: issue condition is accumulator >= MAX_BATCH, or (accumulator>0 and (idle_cnt >= FLUSH_TIMEOUT or flush)). When it holds, latch req_step = min(accumulator, MAX_BATCH) and go to REQ. A sticky halt condition is checked first; if set, go to HALT.
- REQ: req_valid=1; req_step held stable until the handshake. At req_valid&&req_ready, subtract req_step from the accumulator and go to WAIT. req_valid never drops without a handshake.
- WAIT: at rsp_valid, go to HALT with cause FAIL if rsp_fail=1, else return to RUN. rsp_valid outside WAIT is ignored.
- HALT: terminal until reset. halt=1; req_valid=0, init_valid=0; accumulator frozen.

Accumulator:
- Updated in every non-HALT state, INIT included, so no steps are lost.
- next = acc + in_step - (handshake ? req_step : 0), computed at BATCH_WIDTH+1 bits.
- If the result exceeds 2^BATCH_WIDTH-1: saturate and set sticky ovf.

Idle counter:
- Clears on any cycle with in_step != 0 or a handshake; otherwise increments, saturating at FLUSH_TIMEOUT.

cycle_count:
- Increments every cycle from reset release until HALT.
- When max_cycles != 0 and cycle_count >= max_cycles, set sticky maxcyc.

Halt handling:
- Sticky ovf/maxcyc are acted on only in RUN, so an in-flight request and its response complete first.
- Priority: FAIL > OVERFLOW > MAXCYC. A FAIL response overrides a pending sticky flag.
- halt and halt_cause become valid the cycle after entering HALT is decided (registered).

Simultaneous events:
- in_step arriving on the handshake cycle is added in the same update.
- init_done arriving in the first INIT cycle gives a one-cycle init_valid pulse.

Decomposition:
- Package difftest_sched_pkg holds the state enum (INIT, RUN, REQ, WAIT, HALT) and the halt_cause enum (NONE, FAIL, OVERFLOW, MAXCYC).
- Sub-module difftest_step_accum is a saturating add/subtract accumulator with sticky overflow output, parameterised by STEP_WIDTH/BATCH_WIDTH.

Test Plan:
- Init handshake: release reset, init_done after 3 cycles -> init_valid high exactly 3 cycles, state RUN, no req_valid during INIT even with in_step=2 during INIT; pending=6 on RUN entry.
- Batch issue: in_step=8 every cycle, req_ready=1, rsp after 2 cycles, pass -> req_step=64 when pending reaches 64; residual steps retained; no request while in WAIT.
- Timeout flush: in_step=5 once then 0 -> req_valid with req_step=5 after 32 idle cycles; flush=1 gives the same request on the next RUN cycle.
- Backpressure: req_ready low 10 cycles while in_step=1 -> req_valid/req_step stable; pending = prior + 10 - req_step after the handshake.
- Failure: rsp_valid=1, rsp_fail=1 -> halt=1, halt_cause=1, cycle_count frozen, later in_step ignored.
- Max cycles / overflow: max_cycles=100 during WAIT -> response completes, then halt_cause=3. BATCH_WIDTH=8 with req_ready=0 and in_step=255 -> pending saturates at 255, halt_cause=2 after the handshake/response.
